pipe_ctl: RTL and testbench

PIPE_CTL -- requirements
Module: pipe_ctl

---
 rtl/pipe_pkg.sv | 16 +
 rtl/hazard_detect.sv | 14 +
 rtl/pipe_ctl.sv | 128 ++++++++++++
 tb/tb_pipe_ctl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encodings, timeout limit and counter widths for pipe_ctl
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_ERR     = 2'd2
    } state_e;

    localparam int              WAIT_W     = 8;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = 8'd255;

    localparam int               STALL_W   = 16;
    localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard comparator
module hazard_detect (
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       load_use
);

    // Register 0 is hardwired to zero, so a load into it never creates a dependency.
    assign load_use = ex_memread && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipe_ctl.sv
// rtl/pipe_ctl.sv - pipeline stall/flush controller with data-memory wait FSM
module pipe_ctl
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        EX_memread,
    input  logic [4:0]  EX_rt,
    input  logic        MEM_branch,
    input  logic        MEM_alu_zero,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        exmem_en,
    output logic        pc_sel,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        mem_err,
    output logic [15:0] stall_cnt,
    output logic [1:0]  state
);

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                mem_err_q, mem_err_d;
    logic [STALL_W-1:0]  stall_q, stall_d;

    logic load_use;
    logic br_taken;

    hazard_detect u_hazard_detect (
        .ex_memread (EX_memread),
        .ex_rt      (EX_rt),
        .id_rs      (ID_rs),
        .id_rt      (ID_rt),
        .load_use   (load_use)
    );

    assign br_taken = MEM_branch && MEM_alu_zero;

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        mem_err_d   = mem_err_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        exmem_en    = 1'b1;
        pc_sel      = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;

        case (state_q)
            ST_RUN: begin
                // A memory freeze beats branch redirect, which beats a load-use bubble.
                if (mem_req && !mem_ack) begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    exmem_en = 1'b0;
                    state_d  = ST_MEMWAIT;
                    wait_d   = '0;
                end else if (br_taken) begin
                    pc_sel      = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                end else if (load_use) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            ST_MEMWAIT: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                exmem_en = 1'b0;
                if (mem_ack) begin
                    state_d = ST_RUN;
                end else if (wait_q == WAIT_LIMIT) begin
                    state_d   = ST_ERR;
                    mem_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_ERR: begin
                pc_en     = 1'b0;
                ifid_en   = 1'b0;
                exmem_en  = 1'b0;
                mem_err_d = 1'b1;
            end
            default: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                exmem_en = 1'b0;
                state_d  = ST_RUN;
            end
        endcase

        stall_d = stall_q;
        if (!pc_en && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            wait_q    <= '0;
            mem_err_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            mem_err_q <= mem_err_d;
            stall_q   <= stall_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pipe_ctl.sv
// tb/tb_pipe_ctl.sv - randomized self-checking bench for pipe_ctl against a behavioural model
module tb_pipe_ctl;

    logic        clk;
    logic        rst;
    logic [4:0]  ID_rs, ID_rt, EX_rt;
    logic        EX_memread, MEM_branch, MEM_alu_zero, mem_req, mem_ack;
    logic        pc_en, ifid_en, exmem_en, pc_sel;
    logic        ifid_flush, idex_flush, exmem_flush, mem_err;
    logic [15:0] stall_cnt;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 = running, 1 = waiting on memory, 2 = error.
    int m_mode;
    int m_waited;
    int m_err;
    int m_stall;

    pipe_ctl dut (
        .clk          (clk),
        .rst          (rst),
        .ID_rs        (ID_rs),
        .ID_rt        (ID_rt),
        .EX_memread   (EX_memread),
        .EX_rt        (EX_rt),
        .MEM_branch   (MEM_branch),
        .MEM_alu_zero (MEM_alu_zero),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .exmem_en     (exmem_en),
        .pc_sel       (pc_sel),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .exmem_flush  (exmem_flush),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic bit exp_frozen();
        return (m_mode != 0) || (mem_req && !mem_ack);
    endfunction

    function automatic bit exp_lu();
        return EX_memread && (EX_rt != 0) && ((EX_rt == ID_rs) || (EX_rt == ID_rt));
    endfunction

    function automatic bit exp_pc_en();
        bit taken;
        taken = MEM_branch && MEM_alu_zero;
        return !exp_frozen() && !(exp_lu() && !taken);
    endfunction

    // Packed {pc_en, ifid_en, exmem_en, pc_sel, ifid_flush, idex_flush, exmem_flush}
    function automatic logic [6:0] exp_ctl();
        bit fr, lu, tk, en;
        fr = exp_frozen();
        lu = exp_lu();
        tk = MEM_branch && MEM_alu_zero;
        en = exp_pc_en();
        return {en, en, !fr, !fr && tk, !fr && tk, !fr && (tk || lu), !fr && tk};
    endfunction

    task automatic check_now(input string tag);
        chk({tag, "_ctl"}, {25'd0, pc_en, ifid_en, exmem_en, pc_sel, ifid_flush, idex_flush, exmem_flush},
            {25'd0, exp_ctl()});
        chk({tag, "_state"}, {30'd0, state}, m_mode);
        chk({tag, "_stall"}, {16'd0, stall_cnt}, m_stall);
        chk({tag, "_err"}, {31'd0, mem_err}, m_err);
    endtask

    task automatic model_edge();
        if (!exp_pc_en() && m_stall < 65535) m_stall++;
        case (m_mode)
            0: if (mem_req && !mem_ack) begin
                   m_mode   = 1;
                   m_waited = 0;
               end
            1: if (mem_ack) m_mode = 0;
               else begin
                   m_waited++;
                   if (m_waited == 256) begin
                       m_mode = 2;
                       m_err  = 1;
                   end
               end
            default: ;
        endcase
    endtask

    task automatic model_reset();
        m_mode = 0; m_waited = 0; m_err = 0; m_stall = 0;
    endtask

    task automatic set_in(input bit mr, input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                          input bit br, input bit z, input bit rq, input bit ak);
        EX_memread = mr; EX_rt = ert; ID_rs = rs; ID_rt = rt;
        MEM_branch = br; MEM_alu_zero = z; mem_req = rq; mem_ack = ak;
    endtask

    // Check at the falling edge, then advance the model on the rising edge.
    task automatic cycle(input string tag);
        @(negedge clk);
        check_now(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check_now(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        check_now("reset");
        set_in(1, 5'd8, 5'd8, 5'd1, 0, 0, 0, 0);
        #1;
        check_now("reset_lu");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Load-use bubble on ID_rs.
        set_in(1, 5'd8, 5'd8, 5'd3, 0, 0, 0, 0);
        @(negedge clk);
        check_now("lu");
        chk("lu_pc_en", {31'd0, pc_en}, 0);
        chk("lu_idex_flush", {31'd0, idex_flush}, 1);
        @(posedge clk);
        model_edge();
        #1;
        chk("lu_stall", {16'd0, stall_cnt}, 1);

        // Register 0 never hazards.
        set_in(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        @(negedge clk);
        check_now("r0");
        chk("r0_en", {29'd0, pc_en, ifid_en, exmem_en}, 3'b111);
        @(posedge clk);
        model_edge();
        #1;

        // Branch overrides load-use.
        set_in(1, 5'd9, 5'd2, 5'd9, 1, 1, 0, 0);
        @(negedge clk);
        check_now("br_lu");
        chk("br_lu_vals", {25'd0, pc_en, ifid_en, pc_sel, ifid_flush, idex_flush, exmem_flush, exmem_en},
            7'b1111111);
        @(posedge clk);
        model_edge();
        #1;

        // Request completing in the same cycle does not stall.
        set_in(0, 0, 0, 0, 0, 0, 1, 1);
        cycle("req_ack");
        chk("req_ack_state", {30'd0, state}, 0);

        // Three no-ack cycles then ack.
        pulse_reset("rst1");
        set_in(0, 0, 0, 0, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cycle("mw");
            chk("mw_state", {30'd0, state}, 1);
        end
        mem_ack = 1'b1;
        cycle("mw_ack");
        chk("mw_done_state", {30'd0, state}, 0);
        chk("mw_done_stall", {16'd0, stall_cnt}, 4);

        // Timeout into ERR.
        pulse_reset("rst2");
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        cycle("to_enter");
        for (int i = 0; i < 255; i++) cycle("to_wait");
        chk("to_before_state", {30'd0, state}, 1);
        chk("to_before_err", {31'd0, mem_err}, 0);
        cycle("to_last");
        chk("to_state", {30'd0, state}, 2);
        chk("to_err", {31'd0, mem_err}, 1);
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) cycle("err_hold");
        chk("err_hold_state", {30'd0, state}, 2);

        // Asynchronous reset out of ERR.
        rst = 1'b1;
        #1;
        chk("async_state", {30'd0, state}, 0);
        chk("async_err", {31'd0, mem_err}, 0);
        chk("async_stall", {16'd0, stall_cnt}, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset while waiting on memory.
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        cycle("mw2");
        cycle("mw2b");
        pulse_reset("rst_mw");
        set_in(1, 5'd4, 5'd1, 5'd4, 0, 0, 0, 0);
        cycle("post_rst");

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            set_in($urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 1),
                   ($urandom_range(0, 3) == 0), $urandom_range(0, 1));
            cycle("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
